// File: rtl/example_pulse_pkg.sv
// Shared types and constants for the example_pulse_monitor slice.
package example_pulse_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HIGH = 1'b1
  } state_e;

  localparam int unsigned REC_WIDTH_W = 8;
  localparam int unsigned FIFO_DEPTH  = 2;

  typedef struct packed {
    logic                   sat;
    logic [REC_WIDTH_W-1:0] width;
  } pulse_rec_t;

endpackage

// File: rtl/example_pulse_fifo.sv
// Small synchronous record FIFO; push and pop together while full is legal.
module example_pulse_fifo
  import example_pulse_pkg::*;
#(
  parameter int unsigned DATA_W = REC_WIDTH_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == OCC_W'(FIFO_DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees the slot the concurrent push needs, so full does not block it.
  assign do_push = push & (~full | do_pop);
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= PTR_W'(wr_ptr + 1'b1);
      end
      if (do_pop) begin
        rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= OCC_W'(count + 1'b1);
        2'b01:   count <= OCC_W'(count - 1'b1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/example_pulse_monitor.sv
// Counts rising edges on z and records each high pulse's width into a 2-entry FIFO.
// Optional macro EXAMPLE_PULSE_MIN_FILTER_EN discards unsaturated pulses shorter than MIN_W.
module example_pulse_monitor
  import example_pulse_pkg::*;
#(
  parameter int unsigned WIDTH_W = 8,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned MIN_W   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               z,
  input  logic               clr,
  output logic               rec_valid,
  input  logic               rec_ready,
  output logic [WIDTH_W-1:0] rec_width,
  output logic               rec_sat,
  output logic [CNT_W-1:0]   edge_count,
  output logic               overflow
);

  localparam int unsigned        REC_W     = WIDTH_W + 1;
  localparam logic [WIDTH_W-1:0] WIDTH_MAX = '1;
  localparam logic [WIDTH_W-1:0] MIN_WIDTH = WIDTH_W'(MIN_W);
`ifdef EXAMPLE_PULSE_MIN_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  state_e             state;
  logic               z_q;
  logic [WIDTH_W-1:0] width_cnt;
  logic               sat;
  logic               pend_valid;
  logic [REC_W-1:0]   pend_rec;
  logic [REC_W-1:0]   head;
  logic               full;
  logic               empty;
  logic               rise_c;
  logic               fall_c;
  logic               keep_c;
  logic               pop_c;
  logic               drop_c;

  // z_q resets high so a pulse already in progress at reset release is ignored.
  assign rise_c = z & ~z_q & (state == IDLE);
  assign fall_c = (state == HIGH) & ~z;
  assign keep_c = ~FILTER_EN | sat | (width_cnt >= MIN_WIDTH);
  assign pop_c  = ~empty & rec_ready;
  assign drop_c = pend_valid & full & ~pop_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      z_q        <= 1'b1;
      width_cnt  <= '0;
      sat        <= 1'b0;
      pend_valid <= 1'b0;
      pend_rec   <= '0;
      edge_count <= '0;
      overflow   <= 1'b0;
    end else begin
      z_q        <= z;
      pend_valid <= fall_c & keep_c;
      if (fall_c) begin
        pend_rec <= {sat, width_cnt};
      end

      case (state)
        IDLE: begin
          if (rise_c) begin
            width_cnt <= WIDTH_W'(1);
            sat       <= 1'b0;
            state     <= HIGH;
          end
        end
        HIGH: begin
          if (z) begin
            if (width_cnt == WIDTH_MAX) begin
              sat <= 1'b1;
            end else begin
              width_cnt <= WIDTH_W'(width_cnt + 1'b1);
            end
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Clear first, then count a coincident rise.
      if (clr) begin
        edge_count <= rise_c ? CNT_W'(1) : '0;
      end else if (rise_c) begin
        edge_count <= CNT_W'(edge_count + 1'b1);
      end

      // A drop in the clearing cycle still leaves the flag set.
      if (drop_c) begin
        overflow <= 1'b1;
      end else if (clr) begin
        overflow <= 1'b0;
      end
    end
  end

  example_pulse_fifo #(
    .DATA_W(REC_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (pend_valid),
    .push_data(pend_rec),
    .pop      (pop_c),
    .head_data(head),
    .full     (full),
    .empty    (empty)
  );

  assign rec_valid = ~empty;
  assign rec_sat   = head[WIDTH_W];
  assign rec_width = head[WIDTH_W-1:0];

endmodule

// File: tb/tb_example_pulse_monitor.sv
// Self-checking bench for example_pulse_monitor: pulse table plus handshake/overflow/wrap sequences.
module tb_example_pulse_monitor;
  import example_pulse_pkg::*;

  localparam int unsigned WIDTH_W = 8;
  localparam int unsigned CNT_W   = 4;
`ifdef EXAMPLE_PULSE_MIN_FILTER_EN
  localparam bit SHORT_KEPT = 1'b0;
`else
  localparam bit SHORT_KEPT = 1'b1;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               z;
  logic               clr;
  logic               rec_ready;
  logic               rec_valid;
  logic [WIDTH_W-1:0] rec_width;
  logic               rec_sat;
  logic [CNT_W-1:0]   edge_count;
  logic               overflow;

  int errors = 0;
  int checks = 0;
  int unsigned exp_edges = 0;
  pulse_rec_t exp_q[$];

  typedef struct {
    int unsigned len;
    int unsigned gap;
    logic        keep;
    pulse_rec_t  exp;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  example_pulse_monitor #(
    .WIDTH_W(WIDTH_W),
    .CNT_W  (CNT_W),
    .MIN_W  (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .z         (z),
    .clr       (clr),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready),
    .rec_width (rec_width),
    .rec_sat   (rec_sat),
    .edge_count(edge_count),
    .overflow  (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse(input int unsigned len);
    z = 1'b1;
    repeat (len) tick();
    z = 1'b0;
    tick();
    exp_edges = (exp_edges + 1) % 16;
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (exp_q.size() == 0 && rec_valid === 1'b0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk(name, 32'(done), 32'd1);
  endtask

  // Scoreboard: every accepted record is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rec_valid === 1'b1 && rec_ready === 1'b1) begin
      pulse_rec_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL record_unexpected: got width=%0d sat=%0d expected none", rec_width, rec_sat);
      end else begin
        e = exp_q.pop_front();
        if (rec_width !== e.width || rec_sat !== e.sat) begin
          errors++;
          $display("FAIL record: got width=%0d sat=%0d expected width=%0d sat=%0d",
                   rec_width, rec_sat, e.width, e.sat);
        end
      end
    end
  end

  initial begin
    int unsigned lat_len;
    tbl[0] = '{3,   1, 1'b1,       '{1'b0, 8'd3}};
    tbl[1] = '{1,   0, SHORT_KEPT, '{1'b0, 8'd1}};
    tbl[2] = '{4,   2, 1'b1,       '{1'b0, 8'd4}};
    tbl[3] = '{2,   0, 1'b1,       '{1'b0, 8'd2}};
    tbl[4] = '{255, 2, 1'b1,       '{1'b0, 8'd255}};
    tbl[5] = '{256, 2, 1'b1,       '{1'b1, 8'd255}};
    tbl[6] = '{300, 2, 1'b1,       '{1'b1, 8'd255}};
    tbl[7] = '{1,   3, SHORT_KEPT, '{1'b0, 8'd1}};

    // Reset with z held high; the in-progress pulse must not be recorded.
    rst_n = 1'b0; z = 1'b1; clr = 1'b0; rec_ready = 1'b1;
    repeat (3) tick();
    chk("rst_valid", 32'(rec_valid), 32'd0);
    chk("rst_width", 32'(rec_width), 32'd0);
    chk("rst_sat", 32'(rec_sat), 32'd0);
    chk("rst_edges", 32'(edge_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    z = 1'b0;
    repeat (2) tick();
    chk("held_high_no_rec", 32'(rec_valid), 32'd0);
    chk("held_high_no_edge", 32'(edge_count), 32'd0);
    exp_edges = 0;
    exp_q.push_back('{1'b0, 8'd3});
    pulse(3);
    wait_drain("drain_first");
    chk("first_edges", 32'(edge_count), 32'(exp_edges));

    // Latency: record visible one cycle after the falling sample, for one cycle.
    lat_len = SHORT_KEPT ? 1 : 2;
    exp_q.push_back('{1'b0, 8'(lat_len)});
    z = 1'b1;
    repeat (lat_len) tick();
    z = 1'b0;
    tick();
    exp_edges++;
    chk("lat_not_yet", 32'(rec_valid), 32'd0);
    tick();
    chk("lat_valid", 32'(rec_valid), 32'd1);
    chk("lat_width", 32'(rec_width), 32'(lat_len));
    tick();
    chk("lat_one_cycle", 32'(rec_valid), 32'd0);

    // Overflow: two records buffered, third dropped in a clr cycle.
    rec_ready = 1'b0;
    exp_q.push_back('{1'b0, 8'd2});
    exp_q.push_back('{1'b0, 8'd2});
    pulse(2); tick();
    pulse(2); tick();
    chk("full_valid", 32'(rec_valid), 32'd1);
    chk("full_head", 32'(rec_width), 32'd2);
    chk("full_no_ovf", 32'(overflow), 32'd0);
    pulse(2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_edges = 0;
    chk("drop_set_wins", 32'(overflow), 32'd1);
    chk("drop_clr_edges", 32'(edge_count), 32'd0);
    repeat (3) tick();
    chk("hold_valid", 32'(rec_valid), 32'd1);
    rec_ready = 1'b1;
    wait_drain("drain_overflow");
    chk("ovf_sticky", 32'(overflow), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Table of pulse lengths including saturation boundaries.
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].keep) exp_q.push_back(tbl[i].exp);
      pulse(tbl[i].len);
      repeat (tbl[i].gap) tick();
    end
    wait_drain("drain_table");
    chk("table_edges", 32'(edge_count), 32'(exp_edges));

    // Edge counter wrap, then clr coinciding with a rise.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_edges = 0;
    for (int i = 1; i <= 16; i++) begin
      if (SHORT_KEPT) exp_q.push_back('{1'b0, 8'd1});
      pulse(1);
      tick();
      if (i == 15) chk("wrap_15", 32'(edge_count), 32'd15);
      if (i == 16) chk("wrap_0", 32'(edge_count), 32'd0);
    end
    if (SHORT_KEPT) exp_q.push_back('{1'b0, 8'd1});
    z = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_with_rise", 32'(edge_count), 32'd1);
    z = 1'b0;
    repeat (2) tick();
    wait_drain("drain_wrap");

    // Reset mid-pulse discards everything.
    z = 1'b1;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    z = 1'b0; rst_n = 1'b1;
    repeat (5) tick();
    chk("midreset_no_rec", 32'(rec_valid), 32'd0);
    chk("midreset_edges", 32'(edge_count), 32'd0);
    exp_edges = 0;

`ifdef EXAMPLE_PULSE_MIN_FILTER_EN
    exp_q.push_back('{1'b0, 8'd2});
    pulse(1); tick();
    pulse(2); tick();
    pulse(1); tick();
    wait_drain("drain_filter");
    chk("filter_edges", 32'(edge_count), 32'd3);
    chk("filter_no_ovf", 32'(overflow), 32'd0);
`endif

    repeat (10) tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/example_pulse_monitor.md
Name: example_pulse_monitor

Overview:
- Downstream consumer of the `example` block's `z` output (`z = a|b`), in the same clock domain.
- Detects rising edges on `z`, counts them, and measures each high pulse's width in clock cycles.
- Buffers completed-pulse records in a 2-entry FIFO and offers them over a valid/ready interface.
- Used as the observation/checking stage behind `example` in block-level builds.

Parameters:
- WIDTH_W, 8: width of the pulse-width field; saturates at 2**WIDTH_W-1.
- CNT_W, 16: width of the rising-edge counter; wraps modulo 2**CNT_W.
- MIN_W, 2: minimum recorded pulse width; used only when EXAMPLE_PULSE_MIN_FILTER_EN is defined.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  reset; synchronous, active-low.
- z  input  1  monitored signal; `z` output of `example`.
- clr  input  1  synchronous clear of edge_count and overflow.
- rec_valid  output  1  record available at FIFO head.
- rec_ready  input  1  consumer accepts record.
- rec_width  output  WIDTH_W  pulse width of head record, in cycles.
- rec_sat  output  1  head record's width saturated.
- edge_count  output  CNT_W  number of rising edges seen.
- overflow  output  1  sticky flag: a record was dropped because the FIFO was full.

Behaviour:
- Interface (already decided): single clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset (rst_n=0 at posedge):
  - state=IDLE; z_q=1, so a pulse already in progress at reset release is never recorded.
  - width_cnt=0, edge_count=0, overflow=0, FIFO empty.
  - Outputs: rec_valid=0, rec_width=0, rec_sat=0.
- Reset mid-pulse or mid-handshake: all state discarded, no record emitted.
- Edge detect: rise = z & ~z_q; z_q <= z every cycle.
- FSM, two states:
  - IDLE, rise: width_cnt<=1, sat<=0, edge_count++, go to HIGH.
  - IDLE, z low or already-high (post-reset): stay.
  - HIGH, z=1: width_cnt++ saturating at max; sat<=1 when an increment is attempted at max.
  - HIGH, z=0: push {sat,width_cnt} to FIFO, go to IDLE.
- Width semantics: z sampled high on N consecutive posedges yields rec_width=N.
  - Example: a 1-cycle pulse gives width 1.
  - Pulses >= 2**WIDTH_W cycles: rec_width=max, rec_sat=1.
- Latency: rec_valid rises on the posedge after the one that samples z low. Record appears 1 cycle after the falling sample.
- Back-to-back pulses: HIGH->IDLE takes one low sample. A rise on the very next sample starts a new pulse with no loss.
- FIFO: 2 entries.
  - rec_valid = ~empty; rec_width/rec_sat are driven from the head entry, and are 0 when empty.
  - Pop when rec_valid & rec_ready.
  - Push and pop in the same cycle while full: both happen; no drop.
  - Push while full with no pop: record dropped, overflow<=1 (sticky).
- Handshake: rec_valid, once asserted, holds and head data stays stable until accepted. rec_ready may be held high permanently.
- Counters:
  - edge_count wraps from 2**CNT_W-1 to 0.
  - clr zeroes edge_count and overflow; the FIFO and FSM are unaffected.
  - clr in the same cycle as a rise: result edge_count=1 (clear, then count).
  - clr in the same cycle as a drop: overflow=1 (set wins).

Optional Feature:
- Macro: EXAMPLE_PULSE_MIN_FILTER_EN.
- Defined: on HIGH->IDLE, if width_cnt < MIN_W and sat=0, no push occurs; the record is silently discarded.
  - edge_count still counts the rise.
  - A discarded record never sets overflow.
- Undefined: every completed pulse is pushed; MIN_W is unused.

Decomposition:
- Package example_pulse_pkg holds:
  - state_e enum {IDLE, HIGH}.
  - pulse_rec_t struct {logic sat; logic [WIDTH_W-1:0] width}, with a width-parameterised localparam default of 8.
  - localparam FIFO_DEPTH=2.
- Sub-module example_pulse_fifo: 2-entry synchronous FIFO.
  - Ports: clk, rst_n, push, push_data, pop, head_data, full, empty.
  - Simultaneous push and pop while full is legal.
- The top holds the FSM, counters and drop/overflow logic.

Test Plan:
- Reset with z=1 held, release, z falls, then 3-cycle pulse -> exactly one record: width=3, sat=0; edge_count=1.
- 1-cycle pulse with rec_ready=1 -> rec_valid high for exactly 1 cycle, width=1, one cycle after the falling sample.
- rec_ready=0, three 2-cycle pulses -> first two buffered, third dropped; overflow=1; draining yields width 2, 2; then rec_valid=0.
- 300-cycle pulse, WIDTH_W=8 -> rec_width=255, rec_sat=1.
- CNT_W=4, 17 pulses; clr asserted on the 17th rise -> edge_count wraps 15->0 at pulse 16, then reads 1 after the clr cycle.
- With EXAMPLE_PULSE_MIN_FILTER_EN, MIN_W=2: pulse widths 1, 2, 1 -> single record, width=2; edge_count=3.
